ifft_bank_serializer: RTL and testbench
=======================================

# ifft_bank_serializer

Parallel-to-burst serializer: the transmit-side counterpart to the burst-capture upsampler. It accepts a full bank of Nfft complex samples in one cycle and emits them as a contiguous, naturally-ordered indexed burst (index 0..Nfft-1) into the FFT/IFFT streaming input. A one-deep pending bank lets the next bank be loaded while the current burst streams, so consecutive bursts run back-to-back with no idle cycle. The output uses a valid/ready handshake so the downstream core can stall the burst.

## Interface
- dwidth, 16, bits per real/imag component
- Nfft, 32, samples per bank/burst; power of two, >= 2
- iwidth, $clog2(Nfft), index width
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- load  in  1  strobe: din bank valid this cycle
- din_real, din_imag  in  [Nfft-1:0][dwidth-1:0]  parallel bank, element k = burst sample k
- load_ready  out  1  bank can be accepted this cycle
- overrun  out  1  sticky: a load was dropped
- dv_out  out  1  output sample valid
- dout_ready  in  1  downstream accepts sample
- dout_real, dout_imag  out  dwidth  current sample
- index_out  out  iwidth  position of current sample in burst
- last_out  out  1  high with dv_out when index_out == Nfft-1

## Operation
- Storage: active bank (being emitted) and pending bank plus pend_valid flag.
- States: IDLE (dv_out=0) and BURST (dv_out=1).
- load_ready = !pend_valid (registered-state only, no path from load).
- Accepted load (load & load_ready):
  - IDLE: bank goes directly to active, index <= 0, state -> BURST.
  - BURST, not final handshake: bank goes to pending, pend_valid <= 1.
  - BURST, final handshake same cycle: bank goes directly to active (pend_valid was 0), index <= 0, stay BURST.
- load while !load_ready: bank discarded, overrun <= 1; cleared only by reset.
- Handshake: sample transfers when dv_out & dout_ready. Index increments by 1 per transfer; unchanged when dout_ready=0 (dout, index_out, last_out held stable).
- Final handshake (transfer with index_out == Nfft-1):
  - pend_valid: pending -> active, pend_valid <= 0, index <= 0, stay BURST.
  - else accepted load this cycle: as above.
  - else: state -> IDLE, index <= 0.
- dout_real/imag = active[index_out]; index wraps only through final-handshake rule.
- Data passed bit-exact; no arithmetic, no scaling.

## Timing
- Reset values: dv_out 0, last_out 0, index_out 0, load_ready 1, overrun 0, dout_real/imag 0 (active bank cleared), pend_valid 0, state IDLE.
- Latency: load accepted in IDLE at edge t -> dv_out=1, index_out=0, sample 0 visible after edge t (next cycle).
- Burst with dout_ready held high: Nfft consecutive dv_out cycles; last_out on the Nfft-th.
- Back-to-back: pending bank's sample 0 appears the cycle after the final handshake; dv_out never drops.
- Reset asserted mid-burst: all state returns to reset values immediately (async); pending bank discarded; first load after deassertion behaves as from IDLE.
- load_ready falls the cycle after the pending bank fills, rises the cycle after pending moves to active.

## Test plan
- Reset, then load bank k -> (1000+k, -k) with Nfft=32, dout_ready=1 -> 32 dv_out cycles, index 0..31, samples in order, last_out only at index 31, then IDLE.
- Two loads (banks A, B) two cycles apart, dout_ready=1 -> 64 contiguous dv_out cycles, A then B, load_ready low from pending-fill until B becomes active.
- Toggle dout_ready randomly (50%) during burst -> index/data held while stalled, every sample delivered exactly once, order preserved.
- Third load while pending full -> dropped, overrun=1 and stays 1; output still A then B only.
- load coincident with final handshake of a burst, pending empty -> next burst index 0 the following cycle, no dv_out gap, overrun stays 0.
- Assert resetn low at index 10 with pending full -> outputs at reset values immediately; after release, single load emits only the new bank.

Source files
------------

// File: rtl/ifft_bank_serializer.sv
// ifft_bank_serializer: accepts a full bank of Nfft complex samples in one
// cycle and streams it out as an indexed valid/ready burst (index 0..Nfft-1).
// A one-deep pending bank allows the next bank to be loaded while the
// current burst streams, so consecutive bursts run with no idle cycle.
module ifft_bank_serializer #(
  parameter int unsigned dwidth = 16,
  parameter int unsigned Nfft   = 32,
  parameter int unsigned iwidth = $clog2(Nfft)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           load,
  input  logic [Nfft-1:0][dwidth-1:0]    din_real,
  input  logic [Nfft-1:0][dwidth-1:0]    din_imag,
  output logic                           load_ready,
  output logic                           overrun,
  output logic                           dv_out,
  input  logic                           dout_ready,
  output logic [dwidth-1:0]              dout_real,
  output logic [dwidth-1:0]              dout_imag,
  output logic [iwidth-1:0]              index_out,
  output logic                           last_out
);

  localparam logic [iwidth-1:0] LAST_IDX = iwidth'(Nfft - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [iwidth-1:0]           index_q, index_d;
  logic [Nfft-1:0][dwidth-1:0] active_real_q, active_real_d;
  logic [Nfft-1:0][dwidth-1:0] active_imag_q, active_imag_d;
  logic [Nfft-1:0][dwidth-1:0] pend_real_q, pend_real_d;
  logic [Nfft-1:0][dwidth-1:0] pend_imag_q, pend_imag_d;
  logic                        pend_valid_q, pend_valid_d;
  logic                        overrun_q, overrun_d;
  logic                        dv_q, dv_d;
  logic                        last_q, last_d;
  logic                        load_ready_q, load_ready_d;
  logic [dwidth-1:0]           dout_real_q, dout_real_d;
  logic [dwidth-1:0]           dout_imag_q, dout_imag_d;

  logic xfer;
  logic final_xfer;
  logic accept;

  // Handshake qualifiers; load acceptance depends only on registered state.
  always_comb begin
    xfer       = (state_q == BURST) & dout_ready;
    final_xfer = xfer & (index_q == LAST_IDX);
    accept     = load & ~pend_valid_q;
  end

  // Next-state, bank movement and registered-output computation.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    active_real_d = active_real_q;
    active_imag_d = active_imag_q;
    pend_real_d   = pend_real_q;
    pend_imag_d   = pend_imag_q;
    pend_valid_d  = pend_valid_q;
    overrun_d     = overrun_q;

    // A load arriving while the pending slot is occupied is lost for good.
    if (load && pend_valid_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          active_real_d = din_real;
          active_imag_d = din_imag;
          index_d       = '0;
          state_d       = BURST;
        end
      end

      BURST: begin
        if (final_xfer) begin
          // End of burst: chain the pending bank, else a same-cycle load,
          // else fall back to idle.
          index_d = '0;
          if (pend_valid_q) begin
            active_real_d = pend_real_q;
            active_imag_d = pend_imag_q;
            pend_valid_d  = 1'b0;
          end else if (accept) begin
            active_real_d = din_real;
            active_imag_d = din_imag;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            index_d = index_q + iwidth'(1);
          end
          if (accept) begin
            pend_real_d  = din_real;
            pend_imag_d  = din_imag;
            pend_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase

    // Outputs are precomputed from next state so they come straight off flops.
    dv_d         = (state_d == BURST);
    last_d       = (state_d == BURST) && (index_d == LAST_IDX);
    load_ready_d = ~pend_valid_d;
    dout_real_d  = active_real_d[index_d];
    dout_imag_d  = active_imag_d[index_d];
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      index_q       <= '0;
      active_real_q <= '0;
      active_imag_q <= '0;
      pend_real_q   <= '0;
      pend_imag_q   <= '0;
      pend_valid_q  <= 1'b0;
      overrun_q     <= 1'b0;
      dv_q          <= 1'b0;
      last_q        <= 1'b0;
      load_ready_q  <= 1'b1;
      dout_real_q   <= '0;
      dout_imag_q   <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      active_real_q <= active_real_d;
      active_imag_q <= active_imag_d;
      pend_real_q   <= pend_real_d;
      pend_imag_q   <= pend_imag_d;
      pend_valid_q  <= pend_valid_d;
      overrun_q     <= overrun_d;
      dv_q          <= dv_d;
      last_q        <= last_d;
      load_ready_q  <= load_ready_d;
      dout_real_q   <= dout_real_d;
      dout_imag_q   <= dout_imag_d;
    end
  end

  assign load_ready = load_ready_q;
  assign overrun    = overrun_q;
  assign dv_out     = dv_q;
  assign last_out   = last_q;
  assign index_out  = index_q;
  assign dout_real  = dout_real_q;
  assign dout_imag  = dout_imag_q;

endmodule

// File: tb/tb_ifft_bank_serializer.sv
// Directed self-checking bench for ifft_bank_serializer (Nfft=32, dwidth=16).
module tb_ifft_bank_serializer;

  localparam int unsigned DW = 16;
  localparam int unsigned NF = 32;
  localparam int unsigned IW = 5;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [IW-1:0] idx;
  } samp_t;

  logic                     clk = 1'b0;
  logic                     resetn;
  logic                     load;
  logic [NF-1:0][DW-1:0]    din_real;
  logic [NF-1:0][DW-1:0]    din_imag;
  logic                     load_ready;
  logic                     overrun;
  logic                     dv_out;
  logic                     dout_ready;
  logic [DW-1:0]            dout_real;
  logic [DW-1:0]            dout_imag;
  logic [IW-1:0]            index_out;
  logic                     last_out;

  int    checks   = 0;
  int    failures = 0;
  int    dv_total = 0;
  samp_t sb[$];

  ifft_bank_serializer #(.dwidth(DW), .Nfft(NF), .iwidth(IW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .load_ready (load_ready),
    .overrun    (overrun),
    .dv_out     (dv_out),
    .dout_ready (dout_ready),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .index_out  (index_out),
    .last_out   (last_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bank "seed": real = seed*1000 + k, imag = -(k + (seed-1)*100).
  function automatic logic [DW-1:0] exp_re(input int seed, input int k);
    return DW'(seed * 1000 + k);
  endfunction

  function automatic logic [DW-1:0] exp_im(input int seed, input int k);
    return DW'(-(k + (seed - 1) * 100));
  endfunction

  // Present a bank with load=1 for the next edge; push to scoreboard if it will be accepted.
  task automatic present(input int seed, input bit expect_accept);
    samp_t s;
    for (int k = 0; k < NF; k++) begin
      din_real[k] = exp_re(seed, k);
      din_imag[k] = exp_im(seed, k);
      if (expect_accept) begin
        s.re  = exp_re(seed, k);
        s.im  = exp_im(seed, k);
        s.idx = IW'(k);
        sb.push_back(s);
      end
    end
    load = 1'b1;
  endtask

  // Check the visible sample against the scoreboard head, then advance one clock.
  task automatic step();
    samp_t s;
    if (dv_out) begin
      dv_total++;
      if (sb.size() == 0) begin
        chk("unexpected_dv", 32'(dv_out), 32'd0);
      end else begin
        s = sb[0];
        chk("idx",  32'(index_out), 32'(s.idx));
        chk("re",   32'(dout_real), 32'(s.re));
        chk("im",   32'(dout_imag), 32'(s.im));
        chk("last", 32'(last_out),  32'(s.idx == IW'(NF - 1)));
        if (dout_ready) void'(sb.pop_front());
      end
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Run until idle with nothing expected, bounded by a cycle budget.
  task automatic drain(input bit rnd);
    int guard = 0;
    while ((dv_out || sb.size() != 0) && guard < 1000) begin
      if (rnd) dout_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    chk("drain_timeout", 32'(guard < 1000), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    dout_ready = 1'b1;
  endtask

  initial begin
    resetn     = 1'b0;
    load       = 1'b0;
    dout_ready = 1'b1;
    din_real   = '0;
    din_imag   = '0;
    #12;
    chk("rst_dv",    32'(dv_out),     32'd0);
    chk("rst_last",  32'(last_out),   32'd0);
    chk("rst_idx",   32'(index_out),  32'd0);
    chk("rst_lrdy",  32'(load_ready), 32'd1);
    chk("rst_ovr",   32'(overrun),    32'd0);
    chk("rst_re",    32'(dout_real),  32'd0);
    chk("rst_im",    32'(dout_imag),  32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single burst, ready held high.
    dv_total = 0;
    present(1, 1'b1);
    step();
    chk("t1_lat_dv",  32'(dv_out),    32'd1);
    chk("t1_lat_idx", 32'(index_out), 32'd0);
    chk("t1_lat_re",  32'(dout_real), 32'd1000);
    drain(1'b0);
    chk("t1_count", 32'(dv_total), 32'd32);
    chk("t1_idle",  32'(dv_out),   32'd0);

    // Back-to-back banks A then B, B loaded two cycles later.
    dv_total = 0;
    present(1, 1'b1);
    step();
    step();
    present(2, 1'b1);
    step();
    chk("t2_lrdy_low", 32'(load_ready), 32'd0);
    for (int i = 0; i < 29; i++) step();
    chk("t2_a31_idx",  32'(index_out),  32'd31);
    chk("t2_a31_lrdy", 32'(load_ready), 32'd0);
    step();
    chk("t2_b0_dv",   32'(dv_out),     32'd1);
    chk("t2_b0_re",   32'(dout_real),  32'd2000);
    chk("t2_b0_lrdy", 32'(load_ready), 32'd1);
    drain(1'b0);
    chk("t2_count", 32'(dv_total), 32'd64);

    // Random backpressure with a pending bank.
    present(1, 1'b1);
    step();
    present(2, 1'b1);
    step();
    chk("t3_lrdy_low", 32'(load_ready), 32'd0);
    drain(1'b1);

    // Load coincident with the final handshake, pending empty.
    dv_total = 0;
    present(1, 1'b1);
    step();
    for (int i = 0; i < 40 && index_out != IW'(NF - 1); i++) step();
    chk("t5_at31", 32'(index_out), 32'd31);
    present(2, 1'b1);
    step();
    chk("t5_dv",   32'(dv_out),    32'd1);
    chk("t5_idx",  32'(index_out), 32'd0);
    chk("t5_re",   32'(dout_real), 32'd2000);
    chk("t5_ovr",  32'(overrun),   32'd0);
    drain(1'b0);
    chk("t5_count", 32'(dv_total), 32'd64);
    chk("t5_ovr_end", 32'(overrun), 32'd0);

    // Third load while pending is full is dropped.
    dv_total = 0;
    present(1, 1'b1);
    step();
    step();
    present(2, 1'b1);
    step();
    present(3, 1'b0);
    step();
    chk("t4_ovr",  32'(overrun),    32'd1);
    chk("t4_lrdy", 32'(load_ready), 32'd0);
    drain(1'b0);
    chk("t4_count",   32'(dv_total), 32'd64);
    chk("t4_ovr_end", 32'(overrun),  32'd1);

    // Reset mid-burst at index 10 with pending full.
    present(1, 1'b1);
    step();
    step();
    present(2, 1'b1);
    step();
    for (int i = 0; i < 40 && index_out != IW'(10); i++) step();
    chk("t6_at10", 32'(index_out), 32'd10);
    #1;
    resetn = 1'b0;
    #1;
    sb.delete();
    chk("t6_dv",   32'(dv_out),     32'd0);
    chk("t6_idx",  32'(index_out),  32'd0);
    chk("t6_last", 32'(last_out),   32'd0);
    chk("t6_lrdy", 32'(load_ready), 32'd1);
    chk("t6_ovr",  32'(overrun),    32'd0);
    chk("t6_re",   32'(dout_real),  32'd0);
    chk("t6_im",   32'(dout_imag),  32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    dv_total = 0;
    present(3, 1'b1);
    step();
    chk("t6_new_re", 32'(dout_real), 32'd3000);
    drain(1'b0);
    chk("t6_count", 32'(dv_total), 32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
